regfile_access_arbiter: RTL

- Sequences every access to the CPU register file.
- Arbitrates between three requesters:
  - decode-stage operand reads
  - execute-stage write-backs, buffered in a small queue
  - status-flag (SREG) updates
- Drives the register file's get_reg_en / reg_write_back / flag_update strobes, at most one per cycle.
- Enforces read-after-write ordering and guarantees reads cannot starve behind write-back drain.

---
 rtl/regfile_access_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/regfile_access_arbiter.sv
// Sequences register-file reads, queued write-backs and SREG updates, one strobe per cycle.
// Optional perf counters are compiled in when REGARB_PERF_EN is defined.
module regfile_access_arbiter #(
  parameter int unsigned DW           = 16,
  parameter int unsigned RAW          = 3,
  parameter int unsigned SREG_IDX     = 7,
  parameter int unsigned WQ_DEPTH     = 2,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rd_req,
  input  logic [RAW-1:0]              rd_reg1,
  input  logic [RAW-1:0]              rd_reg2,
  output logic                        rd_gnt,
  input  logic                        wb_req,
  input  logic [RAW-1:0]              wb_reg,
  input  logic [DW-1:0]               wb_data,
  output logic                        wb_ready,
  input  logic                        fl_req,
  input  logic [DW-1:0]               fl_data,
  output logic                        fl_gnt,
  output logic                        rf_get_reg_en,
  output logic [RAW-1:0]              rf_reg1,
  output logic [RAW-1:0]              rf_reg2,
  output logic                        rf_reg_write_back,
  output logic [RAW-1:0]              rf_reg_write_code,
  output logic [DW-1:0]               rf_data_in,
  output logic                        rf_flag_update,
  output logic [DW-1:0]               rf_SREG_write,
  output logic [$clog2(WQ_DEPTH):0]   wq_count
`ifdef REGARB_PERF_EN
  ,
  output logic [15:0]                 perf_raw_stall,
  output logic [15:0]                 perf_starve_win,
  output logic [15:0]                 perf_wq_full
`endif
);

  localparam int unsigned PW = $clog2(WQ_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  typedef enum logic [2:0] {ActNone, ActRdStarve, ActDrain, ActFlag, ActRd} act_e;

  logic [RAW-1:0] q_reg_q  [WQ_DEPTH];
  logic [DW-1:0]  q_data_q [WQ_DEPTH];
  logic [PW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]  count_q, count_d;
  logic [SW-1:0]  starve_q, starve_d;

  logic           rd_gnt_q, fl_gnt_q, get_en_q, wr_back_q, flag_upd_q;
  logic [RAW-1:0] reg1_q, reg2_q, wr_code_q;
  logic [DW-1:0]  data_in_q, sreg_q;

  logic           wb_accept, rd_elig, fl_elig, rd_hazard, rd_ok, starved, issue_rd;
  logic [PW-1:0]  slot_off;
  act_e           act;

  always_comb begin
    wb_ready  = (count_q < CW'(WQ_DEPTH));
    wb_accept = wb_req && wb_ready;
    // A request whose grant is still high has already been issued.
    rd_elig   = rd_req && !rd_gnt_q;
    fl_elig   = fl_req && !fl_gnt_q;

    rd_hazard = fl_elig;
    slot_off  = '0;
    for (int i = 0; i < int'(WQ_DEPTH); i++) begin
      slot_off = PW'(i) - rd_ptr_q;
      if ((CW'(slot_off) < count_q) &&
          (q_reg_q[i] == rd_reg1 || q_reg_q[i] == rd_reg2 || q_reg_q[i] == RAW'(SREG_IDX))) begin
        rd_hazard = 1'b1;
      end
    end
    if (wb_accept &&
        (wb_reg == rd_reg1 || wb_reg == rd_reg2 || wb_reg == RAW'(SREG_IDX))) begin
      rd_hazard = 1'b1;
    end

    rd_ok   = rd_elig && !rd_hazard;
    starved = (starve_q >= SW'(STARVE_LIMIT));

    if (rd_ok && starved)   act = ActRdStarve;
    else if (count_q != '0) act = ActDrain;
    else if (fl_elig)       act = ActFlag;
    else if (rd_ok)         act = ActRd;
    else                    act = ActNone;

    issue_rd = (act == ActRdStarve) || (act == ActRd);

    count_d = count_q;
    if (wb_accept && act != ActDrain)       count_d = count_q + CW'(1);
    else if (!wb_accept && act == ActDrain) count_d = count_q - CW'(1);

    if (!rd_req || issue_rd)   starve_d = '0;
    else if (rd_ok && !starved) starve_d = starve_q + SW'(1);
    else                        starve_d = starve_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(WQ_DEPTH); i++) begin
        q_reg_q[i]  <= '0;
        q_data_q[i] <= '0;
      end
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      rd_gnt_q   <= 1'b0;
      fl_gnt_q   <= 1'b0;
      get_en_q   <= 1'b0;
      wr_back_q  <= 1'b0;
      flag_upd_q <= 1'b0;
      reg1_q     <= '0;
      reg2_q     <= '0;
      wr_code_q  <= '0;
      data_in_q  <= '0;
      sreg_q     <= '0;
    end else begin
      rd_gnt_q   <= issue_rd;
      get_en_q   <= issue_rd;
      fl_gnt_q   <= (act == ActFlag);
      flag_upd_q <= (act == ActFlag);
      wr_back_q  <= (act == ActDrain);
      count_q    <= count_d;
      starve_q   <= starve_d;
      if (issue_rd) begin
        reg1_q <= rd_reg1;
        reg2_q <= rd_reg2;
      end
      if (act == ActDrain) begin
        wr_code_q <= q_reg_q[rd_ptr_q];
        data_in_q <= q_data_q[rd_ptr_q];
        rd_ptr_q  <= rd_ptr_q + PW'(1);
      end
      if (act == ActFlag) sreg_q <= fl_data;
      if (wb_accept) begin
        q_reg_q[wr_ptr_q]  <= wb_reg;
        q_data_q[wr_ptr_q] <= wb_data;
        wr_ptr_q           <= wr_ptr_q + PW'(1);
      end
    end
  end

  assign rd_gnt            = rd_gnt_q;
  assign fl_gnt            = fl_gnt_q;
  assign rf_get_reg_en     = get_en_q;
  assign rf_reg1           = reg1_q;
  assign rf_reg2           = reg2_q;
  assign rf_reg_write_back = wr_back_q;
  assign rf_reg_write_code = wr_code_q;
  assign rf_data_in        = data_in_q;
  assign rf_flag_update    = flag_upd_q;
  assign rf_SREG_write     = sreg_q;
  assign wq_count          = count_q;

`ifdef REGARB_PERF_EN
  logic [15:0] raw_stall_q, starve_win_q, wq_full_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_stall_q  <= '0;
      starve_win_q <= '0;
      wq_full_q    <= '0;
    end else begin
      if (rd_elig && rd_hazard && raw_stall_q != '1) raw_stall_q <= raw_stall_q + 16'd1;
      if (act == ActRdStarve && starve_win_q != '1)  starve_win_q <= starve_win_q + 16'd1;
      if (wb_req && !wb_ready && wq_full_q != '1)    wq_full_q <= wq_full_q + 16'd1;
    end
  end

  assign perf_raw_stall  = raw_stall_q;
  assign perf_starve_win = starve_win_q;
  assign perf_wq_full    = wq_full_q;
`endif

endmodule
